// File: rtl/sha256_pkg.sv
// SHA-256 schedule types, widths and sigma helpers shared by the expansion datapath.
// Combinational helpers only; no latency, no flow control.
package sha256_pkg;

  localparam int SHA256_WORD_W = 32;
  localparam int SHA256_BLK_W  = 512;
  localparam int SHA256_ROUNDS = 64;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic [SHA256_WORD_W-1:0] sha256_s0(input logic [SHA256_WORD_W-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [SHA256_WORD_W-1:0] sha256_s1(input logic [SHA256_WORD_W-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_w_step.sv
// One message-schedule expansion step over a 16-word window (word0 in the top 32 bits).
// Purely combinational; no flow control.
module sha256_w_step
  import sha256_pkg::*;
(
  input  logic [SHA256_BLK_W-1:0]  win,
  output logic [SHA256_WORD_W-1:0] w_new,
  output logic [SHA256_BLK_W-1:0]  win_next
);

  localparam int WORD0_HI  = SHA256_BLK_W - 1;
  localparam int WORD1_HI  = SHA256_BLK_W - 1 - 1 * SHA256_WORD_W;
  localparam int WORD9_HI  = SHA256_BLK_W - 1 - 9 * SHA256_WORD_W;
  localparam int WORD14_HI = SHA256_BLK_W - 1 - 14 * SHA256_WORD_W;

  always_comb begin
    w_new = sha256_s0(win[WORD1_HI -: SHA256_WORD_W])
          + win[WORD9_HI -: SHA256_WORD_W]
          + sha256_s1(win[WORD14_HI -: SHA256_WORD_W])
          + win[WORD0_HI -: SHA256_WORD_W];
    win_next = {win[SHA256_BLK_W-SHA256_WORD_W-1:0], w_new};
  end

endmodule

// File: rtl/sha256_w_sched_ctrl.sv
// Streams W[0..ROUNDS-1] of an accepted 512-bit block, one word per cycle; W[0] one cycle after accept.
// blk_ready only in IDLE or on the advancing last word; optional w_stall port under SHA256_W_STALL_EN.
module sha256_w_sched_ctrl
  import sha256_pkg::*;
#(
  parameter int ROUNDS = SHA256_ROUNDS,
  parameter int IDX_W  = 6
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     blk_valid,
  input  logic [SHA256_BLK_W-1:0]  blk_in,
  output logic                     blk_ready,
  output logic                     w_valid,
  output logic [SHA256_WORD_W-1:0] w_data,
  output logic [IDX_W-1:0]         w_idx,
  output logic                     w_last,
  output logic                     busy
`ifdef SHA256_W_STALL_EN
  ,
  input  logic                     w_stall
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

  state_t                    state_q, state_d;
  logic [SHA256_BLK_W-1:0]   window_q, window_d;
  logic [IDX_W-1:0]          t_q, t_d;
  logic                      stall, adv, at_last, accept;
  logic [SHA256_WORD_W-1:0]  w_new;
  logic [SHA256_BLK_W-1:0]   win_shift;
  logic                      step_unused;

`ifdef SHA256_W_STALL_EN
  assign stall = w_stall;
`else
  assign stall = 1'b0;
`endif

  sha256_w_step u_step (
    .win      (window_q),
    .w_new    (w_new),
    .win_next (win_shift)
  );

  // The new word already lives in win_shift; keep the standalone copy visibly sunk.
  assign step_unused = ^w_new;

  always_comb begin
    adv       = (state_q == RUN) && !stall;
    at_last   = (t_q == LAST_IDX);
    blk_ready = (state_q == IDLE) || (adv && at_last);
    accept    = blk_valid && blk_ready;
    state_d   = state_q;
    window_d  = window_q;
    t_d       = t_q;
    if (accept) begin
      state_d  = RUN;
      window_d = blk_in;
      t_d      = '0;
    end else if (adv && at_last) begin
      // Clearing on exit keeps w_data/w_idx straight off the flops and zero in IDLE.
      state_d  = IDLE;
      window_d = '0;
      t_d      = '0;
    end else if (adv) begin
      window_d = win_shift;
      t_d      = t_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= IDLE;
      window_q <= '0;
      t_q      <= '0;
    end else begin
      state_q  <= state_d;
      window_q <= window_d;
      t_q      <= t_d;
    end
  end

  assign w_valid = (state_q == RUN);
  assign busy    = (state_q == RUN);
  assign w_data  = window_q[SHA256_BLK_W-1 -: SHA256_WORD_W];
  assign w_idx   = t_q;
  assign w_last  = (state_q == RUN) && at_last;

endmodule
